// File: rtl/arbitro_memoria.sv
// rtl/arbitro_memoria.sv - round-robin two-port arbiter and sequencer for the 64 KiB x 8 main memory
module arbitro_memoria #(
  parameter int AW = 16,
  parameter int DW = 8
) (
  input  logic          CLK,
  input  logic          RESET_N,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dma_req,
  input  logic          dma_we,
  input  logic [AW-1:0] dma_addr,
  input  logic [DW-1:0] dma_wdata,
  output logic          dma_ack,
  output logic [DW-1:0] dma_rdata,
  output logic          busy,
  output logic [AW-1:0] Direccion,
  output logic          LE,
  inout  wire  [DW-1:0] Datos
);

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, ACK} state_t;

  state_t        state, state_nx;
  logic          grant_dma;
  logic          winner_dma;
  logic          last_dma;
  logic          we_q;
  logic          le_q;
  logic [AW-1:0] addr_q;
  logic [DW-1:0] wdata_q;
  logic          start;

  assign start = (state == IDLE) && (cpu_req || dma_req);

  always_comb begin
    grant_dma = dma_req;
    if (cpu_req && dma_req) grant_dma = !last_dma;
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (cpu_req || dma_req) state_nx = SETUP;
      SETUP:   state_nx = we_q ? STROBE : ACK;
      STROBE:  state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      winner_dma <= 1'b0;
      last_dma   <= 1'b1;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      le_q       <= 1'b1;
      cpu_rdata  <= '0;
      dma_rdata  <= '0;
    end else begin
      if (start) begin
        winner_dma <= grant_dma;
        last_dma   <= grant_dma;
        we_q       <= grant_dma ? dma_we    : cpu_we;
        addr_q     <= grant_dma ? dma_addr  : cpu_addr;
        wdata_q    <= grant_dma ? dma_wdata : cpu_wdata;
      end
      // LE falls together with the data bus enable, so the byte is valid on the falling edge
      le_q <= !((state == SETUP) && we_q);
      if ((state == SETUP) && !we_q) begin
        if (winner_dma) dma_rdata <= Datos;
        else            cpu_rdata <= Datos;
      end
    end
  end

  assign Direccion = addr_q;
  assign LE        = le_q;
  assign Datos     = le_q ? {DW{1'bz}} : wdata_q;
  assign cpu_ack   = (state == ACK) && !winner_dma;
  assign dma_ack   = (state == ACK) &&  winner_dma;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_arbitro_memoria.sv
// tb/tb_arbitro_memoria.sv - scoreboard bench for arbitro_memoria with a negedge-LE memory model
module tb_arbitro_memoria;
  localparam int AW = 16;
  localparam int DW = 8;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          cpu_req, cpu_we, dma_req, dma_we;
  logic [AW-1:0] cpu_addr, dma_addr;
  logic [DW-1:0] cpu_wdata, dma_wdata;
  logic          cpu_ack, dma_ack, busy, LE;
  logic [DW-1:0] cpu_rdata, dma_rdata;
  logic [AW-1:0] Direccion;
  wire  [DW-1:0] Datos;

  arbitro_memoria #(.AW(AW), .DW(DW)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
    .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
    .dma_ack(dma_ack), .dma_rdata(dma_rdata),
    .busy(busy), .Direccion(Direccion), .LE(LE), .Datos(Datos)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [7:0] mem [0:65535];
  int wr_count = 0;
  assign Datos = LE ? mem[Direccion] : 8'hzz;

  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h2000] = 8'h05;
    mem[16'h3000] = 8'h77;
    mem[16'hFFFF] = 8'h11;
    forever begin
      @(negedge LE);
      #1;
      mem[Direccion] = Datos;
      wr_count++;
    end
  end

  typedef struct {
    bit         port;
    bit         rd;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  exp_t sbq[$];
  int   tests = 0;
  int   fails = 0;
  int   le_low = 0;
  logic [7:0] datos_low = 8'h00;
  int   cpu_ack_cnt = 0;
  int   dma_ack_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_exp(input bit port, input bit rd, input logic [7:0] data, input int c);
    exp_t e;
    e.port = port;
    e.rd   = rd;
    e.data = data;
    e.cyc  = c;
    sbq.push_back(e);
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge CLK);
      if (!LE) begin
        le_low++;
        datos_low = Datos;
      end
      if (cpu_ack && dma_ack) chk("ack_exclusive", 0, 1);
      if (cpu_ack) cpu_ack_cnt++;
      if (dma_ack) dma_ack_cnt++;
      if (cpu_ack || dma_ack) begin
        chk("sb_has_entry", sbq.size() > 0, 1);
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          chk("ack_port", dma_ack, e.port);
          chk("ack_cycle", cyc, e.cyc);
          if (e.rd) chk("rdata", e.port ? dma_rdata : cpu_rdata, e.data);
        end
      end
    end
  endtask

  task automatic set_port(input bit port, input bit req, input bit we,
                          input logic [15:0] addr, input logic [7:0] wdata);
    if (port) begin
      dma_req = req; dma_we = we; dma_addr = addr; dma_wdata = wdata;
    end else begin
      cpu_req = req; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    end
  endtask

  task automatic access(input bit port, input bit we, input logic [15:0] addr,
                        input logic [7:0] wdata, input logic [7:0] exp);
    bit got = 1'b0;
    @(negedge CLK);
    set_port(port, 1'b1, we, addr, wdata);
    push_exp(port, !we, exp, cyc + (we ? 3 : 2));
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge CLK);
      if (port ? dma_ack : cpu_ack) got = 1'b1;
      else if (i == 0) set_port(port, 1'b1, !we, ~addr, ~wdata);
    end
    chk("ack_seen", got, 1);
    set_port(port, 1'b0, 1'b0, 16'h0000, 8'h00);
  endtask

  initial begin
    int le0, w0, c0, k, n;
    RESET_N = 1'b0;
    set_port(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    set_port(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    fork
      monitor();
    join_none

    @(negedge CLK);
    chk("rst_le", LE, 1);
    chk("rst_dir", Direccion, 16'h0000);
    chk("rst_cpu_ack", cpu_ack, 0);
    chk("rst_dma_ack", dma_ack, 0);
    chk("rst_cpu_rdata", cpu_rdata, 8'h00);
    chk("rst_dma_rdata", dma_rdata, 8'h00);
    chk("rst_busy", busy, 0);
    RESET_N = 1'b1;

    // both ports read continuously from reset: CPU wins the first tie
    @(negedge CLK);
    set_port(1'b0, 1'b1, 1'b0, 16'h2000, 8'h00);
    set_port(1'b1, 1'b1, 1'b0, 16'h3000, 8'h00);
    k = cyc;
    push_exp(1'b0, 1'b1, 8'h05, k + 2);
    push_exp(1'b1, 1'b1, 8'h77, k + 5);
    push_exp(1'b0, 1'b1, 8'h05, k + 8);
    push_exp(1'b1, 1'b1, 8'h77, k + 11);
    n = 0;
    for (int i = 0; i < 30 && n < 4; i++) begin
      @(negedge CLK);
      if (cpu_ack || dma_ack) n++;
    end
    set_port(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    set_port(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    chk("fair_ack_count", n, 4);

    le0 = le_low;
    access(1'b0, 1'b0, 16'h2000, 8'h00, 8'h05);
    chk("cpu_rd_le_never_low", le_low - le0, 0);
    @(negedge CLK);
    chk("cpu_rdata_held", cpu_rdata, 8'h05);

    le0 = le_low;
    w0 = wr_count;
    access(1'b1, 1'b1, 16'h1000, 8'hA5, 8'h00);
    chk("dma_wr_le_low_cycles", le_low - le0, 1);
    chk("dma_wr_datos", datos_low, 8'hA5);
    chk("dma_wr_count", wr_count - w0, 1);
    chk("mem_1000", mem[16'h1000], 8'hA5);
    access(1'b0, 1'b0, 16'h1000, 8'h00, 8'hA5);

    le0 = le_low;
    w0 = wr_count;
    @(negedge CLK);
    set_port(1'b1, 1'b1, 1'b1, 16'hFFFF, 8'h3C);
    @(negedge CLK);
    chk("busy_setup", busy, 1);
    chk("dir_setup", Direccion, 16'hFFFF);
    RESET_N = 1'b0;
    set_port(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00);
    @(negedge CLK);
    chk("rst_mid_le", LE, 1);
    chk("rst_mid_busy", busy, 0);
    RESET_N = 1'b1;
    repeat (4) @(negedge CLK);
    chk("rst_mid_le_low", le_low - le0, 0);
    chk("rst_mid_wr_count", wr_count - w0, 0);
    chk("rst_mid_mem_ffff", mem[16'hFFFF], 8'h11);
    access(1'b1, 1'b1, 16'hFFFF, 8'h3C, 8'h00);
    chk("mem_ffff", mem[16'hFFFF], 8'h3C);

    c0 = cpu_ack_cnt;
    @(negedge CLK);
    set_port(1'b0, 1'b1, 1'b0, 16'h1000, 8'h00);
    push_exp(1'b0, 1'b1, 8'hA5, cyc + 2);
    @(negedge CLK);
    set_port(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00);
    repeat (8) @(negedge CLK);
    chk("drop_ack_once", cpu_ack_cnt - c0, 1);
    chk("drop_idle", busy, 0);

    chk("sb_drained", sbq.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
